// File: rtl/mac_pkg.sv
// Shared definitions for the floating-point MAC sequencer: state encoding and
// the IEEE-754 +0.0 constant used when a vector has no pairs.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mac_lat_timer.sv
// Loadable down-counter that flags the last cycle of the MAC pipeline latency
// window; expire is high while the count sits at 1.
module mac_lat_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the FP MAC datapath: accepts operand pairs over valid/ready,
// issues them one at a time behind the accumulation feedback hazard, and
// captures the final sum with a one-cycle done pulse.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] mac_a,
  output logic [WIDTH-1:0] mac_b,
  output logic             mac_valid,
  output logic             acc_sel,
  input  logic [WIDTH-1:0] mac_result,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int TW = $clog2(PIPE_LAT + 1);

  // Handshake: a pair transfers on any rising edge where in_valid and in_ready
  // are both high; in_ready is high exactly while the FSM sits in ISSUE and
  // does not depend on in_valid.

  mac_state_e       state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic             first;
  logic             hs;
  logic             expire;

  assign in_ready  = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign hs        = in_ready && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (in_valid) state_nxt = ST_WAIT;
      ST_WAIT:  if (expire) state_nxt = (rem != '0) ? ST_ISSUE : ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Loaded on issue so that the FSM leaves WAIT exactly when the previous
  // accumulation reaches mac_result.
  mac_lat_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (hs),
    .load_val (TW'(PIPE_LAT)),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_a     <= '0;
      mac_b     <= '0;
      mac_valid <= 1'b0;
      acc_sel   <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      rem       <= '0;
      first     <= 1'b0;
    end else begin
      mac_valid <= 1'b0;
      done      <= 1'b0;
      if (state == ST_IDLE && start) begin
        rem   <= len;
        first <= 1'b1;
      end
      if (hs) begin
        mac_a     <= a_in;
        mac_b     <= b_in;
        mac_valid <= 1'b1;
        acc_sel   <= ~first;
        first     <= 1'b0;
        rem       <= rem - 1'b1;
      end
      // first still set in DONE means no pair was issued (len == 0).
      if (state == ST_DONE) begin
        result <= first ? WIDTH'(FP_ZERO) : mac_result;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with an ideal FP accumulator standing in
// for the MAC core and a plain-arithmetic model of the expected dot product.
module tb_mac_seq_ctrl;

  localparam int WIDTH    = 32;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a_in, b_in;
  logic [WIDTH-1:0]  mac_a, mac_b;
  logic              mac_valid;
  logic              acc_sel;
  logic [WIDTH-1:0]  mac_result = '0;
  logic [WIDTH-1:0]  result;
  logic              done;
  logic              busy;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int vec_cnt = 0;

  logic [WIDTH-1:0]   exp_q[$];
  logic [2*WIDTH-1:0] op_q[$];
  logic [2*WIDTH-1:0] exp_op;
  int                 mv_t[$];
  logic               sel_q[$];
  logic [WIDTH-1:0]   pa[256];
  logic [WIDTH-1:0]   pb[256];
  logic [WIDTH-1:0]   fp_tab[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  mac_seq_ctrl #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .acc_sel(acc_sel),
    .mac_result(mac_result), .result(result), .done(done), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Single-precision <-> real for normal numbers and zero (all bench values are exact).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == '0) d = {f[31], 63'b0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // ---------------- ideal MAC core, PIPE_LAT cycles ----------------
  logic [2:0]       pv = '0;
  logic [WIDTH-1:0] sa[3], sb[3];
  logic             ss[3];

  always @(posedge clk) begin
    if (pv[2])
      mac_result <= r2f((ss[2] ? f2r(mac_result) : 0.0) + f2r(sa[2]) * f2r(sb[2]));
    pv    <= {pv[1:0], mac_valid};
    sa[2] <= sa[1]; sa[1] <= sa[0]; sa[0] <= mac_a;
    sb[2] <= sb[1]; sb[1] <= sb[0]; sb[0] <= mac_b;
    ss[2] <= ss[1]; ss[1] <= ss[0]; ss[0] <= acc_sel;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (mac_valid) begin
        mv_t.push_back(cyc);
        sel_q.push_back(acc_sel);
        if (op_q.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          exp_op = op_q.pop_front();
          check("mac_a", mac_a, exp_op[63:32]);
          check("mac_b", mac_b, exp_op[31:0]);
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero();
    check("z_mac_a", mac_a, 0);
    check("z_mac_b", mac_b, 0);
    check("z_result", result, 0);
    check("z_mac_valid", mac_valid, 0);
    check("z_acc_sel", acc_sel, 0);
    check("z_done", done, 0);
    check("z_in_ready", in_ready, 0);
    check("z_busy", busy, 0);
    check("z_state", dbg_state, 0);
  endtask

  // Runs one vector from pa/pb; returns at the negedge of the done cycle so a
  // following call starts back-to-back.
  task automatic run_vector(input int n, input int max_gap, input int stall, input bit poke_start);
    real sum;
    int start_cyc, guard, d;
    logic [WIDTH-1:0] exp_res;
    sum = 0.0;
    for (int i = 0; i < n; i++) sum += f2r(pa[i]) * f2r(pb[i]);
    exp_q.push_back(n == 0 ? 32'h0 : r2f(sum));
    mv_t.delete();
    sel_q.delete();
    start = 1'b1;
    len = LEN_W'(n);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      if (i == 0 && stall > 0) begin
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        for (int s = 0; s < stall; s++) begin
          check("stall_in_ready", in_ready, 1);
          check("stall_mac_valid", mac_valid, 0);
          @(negedge clk);
        end
      end
      a_in = pa[i];
      b_in = pb[i];
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      check("issue_timeout", guard < 50, 1);
      op_q.push_back({pa[i], pb[i]});
      @(negedge clk);
      in_valid = 1'b0;
      a_in = $urandom;
      b_in = $urandom;
      if (i == 0 && poke_start) begin
        start = 1'b1;
        len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        len = LEN_W'(n);
      end
    end
    guard = 0;
    while (!done && guard < 2000) begin @(negedge clk); guard++; end
    check("done_timeout", guard < 2000, 1);
    exp_res = exp_q.pop_front();
    check("result", result, exp_res);
    check("busy_at_done", busy, 0);
    check("in_ready_at_done", in_ready, 0);
    check("mv_count", mv_t.size(), n);
    if (n == 0) check("done_cycle", cyc, start_cyc + 2);
    else if (mv_t.size() > 0) check("done_cycle", cyc, mv_t[mv_t.size()-1] + PIPE_LAT + 1);
    for (int i = 0; i < sel_q.size(); i++) check("acc_sel", sel_q[i], (i != 0));
    for (int i = 1; i < mv_t.size(); i++) begin
      d = mv_t[i] - mv_t[i-1];
      if (max_gap == 0 && stall == 0) check("spacing", d, PIPE_LAT + 1);
      else check("spacing_min", d >= PIPE_LAT + 1, 1);
    end
    vec_cnt++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fp_tab[0] = 32'h3F00_0000; fp_tab[1] = 32'h3F80_0000;
    fp_tab[2] = 32'h3FC0_0000; fp_tab[3] = 32'h4000_0000;
    fp_tab[4] = 32'h4040_0000; fp_tab[5] = 32'h3E80_0000;
    fp_tab[6] = 32'hBF80_0000; fp_tab[7] = 32'h4080_0000;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: three pairs, in_valid always high
    pa[0] = 32'h3F80_0000; pb[0] = 32'h4000_0000;
    pa[1] = 32'h4040_0000; pb[1] = 32'h3F00_0000;
    pa[2] = 32'h4080_0000; pb[2] = 32'h3E80_0000;
    run_vector(3, 0, 0, 0);
    check("t1_result_const", result, 32'h4090_0000);
    repeat (2) @(negedge clk);

    // 2: empty vector
    run_vector(0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // 3: in_valid withheld for 6 cycles in ISSUE
    pa[0] = 32'h4000_0000; pb[0] = 32'h4040_0000;
    pa[1] = 32'h3F00_0000; pb[1] = 32'h4080_0000;
    run_vector(2, 0, 6, 0);
    repeat (2) @(negedge clk);

    // 4: start pulsed during WAIT is ignored
    pa[0] = 32'h3FC0_0000; pb[0] = 32'h4000_0000;
    pa[1] = 32'h3F80_0000; pb[1] = 32'h3E80_0000;
    run_vector(2, 0, 0, 1);
    repeat (2) @(negedge clk);

    // 5: reset in WAIT aborts the vector
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    a_in = 32'h4040_0000; b_in = 32'h4040_0000; in_valid = 1'b1;
    for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
    op_q.push_back({32'h4040_0000, 32'h4040_0000});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero();
    reset = 1'b0;
    repeat (PIPE_LAT + 2) @(negedge clk);
    pa[0] = 32'h4000_0000; pb[0] = 32'h4000_0000;
    run_vector(1, 0, 0, 0);
    check("t5_result_const", result, 32'h4080_0000);
    repeat (2) @(negedge clk);

    // 6: back-to-back start in the done cycle
    pa[0] = 32'h4040_0000; pb[0] = 32'h4000_0000;
    run_vector(1, 0, 0, 0);
    pa[0] = 32'h3F00_0000; pb[0] = 32'h3F80_0000;
    run_vector(1, 0, 0, 0);
    repeat (2) @(negedge clk);

    // maximum length, no wrap of the remaining count
    for (int i = 0; i < 255; i++) begin pa[i] = 32'h3F80_0000; pb[i] = 32'h3F80_0000; end
    run_vector(255, 0, 0, 0);
    check("len255_const", result, 32'h437F_0000);
    repeat (2) @(negedge clk);

    // randomized vectors, random gaps and occasional back-to-back starts
    for (int v = 0; v < 15; v++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        pa[i] = fp_tab[$urandom_range(0, 7)];
        pb[i] = fp_tab[$urandom_range(0, 7)];
      end
      run_vector(n, $urandom_range(0, 3), 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("done_pulses", done_cnt, vec_cnt);
    check("exp_q_empty", exp_q.size(), 0);
    check("op_q_empty", op_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
